pc_seq_ctrl: RTL and testbench
==============================

Name: pc_seq_ctrl

Overview:
Next-PC sequencer for the MIPS fetch stage. Owns the PC register and sequences the 18-bit branch-offset extension path: {imm16, 2'b00} is extended to 32 bits, signed or unsigned, then added to PC+4. Selects among sequential, branch, jump and jump-register targets. Stalls the PC while a branch waits for its compare result from the ALU.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
OFF_WIDTH, 18, width of the shifted branch offset before extension to 32 bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
stall  input  1  pipeline stall; freezes PC and FSM
br_req  input  1  decoded conditional branch in current fetch slot
br_imm  input  16  branch immediate
br_sext  input  1  1 = sign-extend offset, 0 = zero-extend
cmp_valid  input  1  branch compare result valid (level, held until consumed)
cmp_taken  input  1  branch condition true; qualified by cmp_valid
j_req  input  1  J/JAL request
j_index  input  26  jump index field
jr_req  input  1  JR/JALR request
jr_addr  input  32  register jump target
pc  output  32  current PC (registered)
pc_plus4  output  32  pc + 4 (combinational from pc)
br_wait  output  1  1 while FSM is in BR_WAIT
redirect  output  1  registered 1-cycle pulse: PC loaded with a non-sequential target

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_PC, state=RUN, br_tgt=0, redirect=0, br_wait=0. Reset overrides stall and all requests. Reset during BR_WAIT abandons the branch.
- Offset extension: off = {br_imm, 2'b00} (OFF_WIDTH bits). Bits [31:OFF_WIDTH] = br_sext ? off[OFF_WIDTH-1] : 0.
- Branch target: br_calc = pc_plus4 + ext(off), modulo 2^32. Wrap-around is silent.
- Jump target: {pc_plus4[31:28], j_index, 2'b00}.
- JR target: jr_addr used unmodified. Low bits are not masked.
- All PC arithmetic is 32-bit unsigned. No overflow flag.
- FSM states: RUN, BR_WAIT.
- RUN, stall=1: pc, state and br_tgt hold; redirect=0 next cycle.
- RUN, stall=0, request priority jr_req > j_req > br_req > sequential:
  - jr_req: pc<=jr_addr, redirect<=1.
  - j_req: pc<=jump target, redirect<=1.
  - br_req with cmp_valid=1 (same cycle): pc<=cmp_taken ? br_calc : pc_plus4. redirect<=cmp_taken. Stay in RUN.
  - br_req with cmp_valid=0: br_tgt<=br_calc, pc holds, state<=BR_WAIT, redirect<=0.
  - No request: pc<=pc_plus4, redirect<=0.
- BR_WAIT:
  - br_req, j_req and jr_req are ignored.
  - pc holds; br_wait=1 (decoded from state).
  - stall=1: hold everything. cmp_valid is not consumed.
  - stall=0 and cmp_valid=1: pc<=cmp_taken ? br_tgt : pc_plus4. redirect<=cmp_taken. state<=RUN. This is the consume cycle.
  - stall=0 and cmp_valid=0: remain in BR_WAIT.
- cmp_valid is ignored in RUN unless br_req=1 and stall=0.
- redirect is high for exactly one cycle per taken transfer. It is never high two cycles in a row unless two consecutive transfers occur.
- Latency: PC update visible 1 cycle after the deciding edge. A branch resolved in BR_WAIT takes 1 + (cycles waiting) cycles.

Test Plan:
- Reset/sequential: rst=1 for 2 cycles, then no requests for 3 cycles -> pc=0,4,8,C; redirect=0; br_wait=0.
- Same-cycle taken branch, negative offset: pc=0x100, br_req=1, br_imm=16'hFFFE, br_sext=1, cmp_valid=1, cmp_taken=1 -> next pc=0x0FC, redirect=1 for one cycle. Repeat with br_sext=0 -> pc=0x0004_00FC.
- Deferred branch: pc=0x200, br_req=1, br_imm=16'h0010, cmp_valid=0 -> br_wait=1 and pc holds 0x200 for 3 cycles. Then cmp_valid=1, cmp_taken=1 -> pc=0x244, br_wait=0. Repeat with cmp_taken=0 -> pc=0x204, redirect=0.
- Stall in BR_WAIT: in BR_WAIT assert cmp_valid=1 together with stall=1 for 2 cycles -> pc, state unchanged. Drop stall -> branch resolves on that edge.
- Priority/jump/wrap: pc=0x1000_0000, jr_req=j_req=br_req=1, jr_addr=0x8000_0003 -> pc=0x8000_0003. Then j_req=1, j_index=26'h3FFFFFF -> pc=0x8FFF_FFFC. Then pc=0xFFFF_FFFC with no request -> pc=0x0000_0000.
- Reset mid-branch: in BR_WAIT assert rst=1 with cmp_valid=1, cmp_taken=1 -> pc=RESET_PC, state=RUN, redirect=0.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pc_seq_ctrl
//
// Next-PC sequencer for the MIPS fetch stage. Owns the PC register and picks
// the next fetch address from four sources:
//   - sequential     : pc + 4
//   - branch         : pc + 4 + ext({br_imm, 2'b00})  (signed or unsigned)
//   - jump (J/JAL)   : {pc_plus4[31:28], j_index, 2'b00}
//   - jump-register  : jr_addr, used exactly as supplied
//
// A conditional branch whose compare result is not ready in its fetch slot
// parks the sequencer in BR_WAIT. The PC holds there until the ALU delivers
// cmp_valid, and the captured branch target is then taken or dropped.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-high reset
//   stall      in   1   pipeline stall; freezes PC and FSM
//   br_req     in   1   conditional branch in the current fetch slot
//   br_imm     in  16   branch immediate
//   br_sext    in   1   1 = sign-extend branch offset, 0 = zero-extend
//   cmp_valid  in   1   branch compare result valid (level)
//   cmp_taken  in   1   branch condition true, qualified by cmp_valid
//   j_req      in   1   J/JAL request
//   j_index    in  26   jump index field
//   jr_req     in   1   JR/JALR request
//   jr_addr    in  32   register jump target
//   pc         out 32   current PC (registered)
//   pc_plus4   out 32   pc + 4 (combinational from pc)
//   br_wait    out  1   high while waiting for a branch compare result
//   redirect   out  1   one-cycle pulse after a non-sequential PC load
// -----------------------------------------------------------------------------
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned OFF_WIDTH = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_req,
  input  logic [15:0] br_imm,
  input  logic        br_sext,
  input  logic        cmp_valid,
  input  logic        cmp_taken,
  input  logic        j_req,
  input  logic [25:0] j_index,
  input  logic        jr_req,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        br_wait,
  output logic        redirect
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_br_tgt;   // branch target captured when the compare is late
  logic        r_redirect;

  // ---------------------------------------------------------------------------
  // Target arithmetic (all 32-bit unsigned, wrap-around is silent)
  // ---------------------------------------------------------------------------
  logic [OFF_WIDTH-1:0] w_off;
  logic                 w_ext_fill;
  logic [31:0]          w_off_ext;
  logic [31:0]          w_pc_plus4;
  logic [31:0]          w_br_calc;
  logic [31:0]          w_j_tgt;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Word offset: immediate shifted left by two, sized to the offset path.
  assign w_off = OFF_WIDTH'({br_imm, 2'b00});

  // Upper bits replicate the offset MSB only when sign extension is asked for.
  assign w_ext_fill = br_sext & w_off[OFF_WIDTH-1];
  assign w_off_ext  = {{(32-OFF_WIDTH){w_ext_fill}}, w_off};

  assign w_br_calc  = w_pc_plus4 + w_off_ext;

  // Jump stays inside the 256 MB region of the delay-slot address.
  assign w_j_tgt    = {w_pc_plus4[31:28], j_index, 2'b00};

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  //
  // In RUN the request priority is jr > j > br > sequential. A branch with its
  // compare result available in the same slot resolves immediately; otherwise
  // the target is captured and the FSM waits in BR_WAIT, where new requests
  // are ignored and the PC holds. stall freezes everything, including an
  // already-valid compare result, which stays pending until stall drops.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every branch of the
  // decision below reads the pre-edge values of r_pc/r_state/r_br_tgt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_br_tgt   <= 32'd0;
      r_redirect <= 1'b0;
    end else if (stall) begin
      r_redirect <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        RUN: begin
          if (jr_req) begin
            r_pc       <= jr_addr;
            r_redirect <= 1'b1;
          end else if (j_req) begin
            r_pc       <= w_j_tgt;
            r_redirect <= 1'b1;
          end else if (br_req) begin
            if (cmp_valid) begin
              r_pc       <= cmp_taken ? w_br_calc : w_pc_plus4;
              r_redirect <= cmp_taken;
            end else begin
              // Compare not ready: remember the target, hold the PC.
              r_br_tgt <= w_br_calc;
              r_state  <= BR_WAIT;
            end
          end else begin
            r_pc <= w_pc_plus4;
          end
        end

        BR_WAIT: begin
          // Consume cycle: the branch resolves against the captured target.
          if (cmp_valid) begin
            r_pc       <= cmp_taken ? r_br_tgt : w_pc_plus4;
            r_redirect <= cmp_taken;
            r_state    <= RUN;
          end
        end

        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign br_wait  = (r_state == BR_WAIT);
  assign redirect = r_redirect;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_seq_ctrl
//
// Self-checking bench for pc_seq_ctrl: a table of directed vectors, a few
// hand-written multi-cycle sequences (stall while waiting, priority/jump/wrap,
// reset mid-branch) and a randomized run compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_pc_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_req;
  logic [15:0] br_imm;
  logic        br_sext;
  logic        cmp_valid;
  logic        cmp_taken;
  logic        j_req;
  logic [25:0] j_index;
  logic        jr_req;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        br_wait;
  logic        redirect;

  int checks = 0;
  int errors = 0;

  pc_seq_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .OFF_WIDTH (18)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_req    (br_req),
    .br_imm    (br_imm),
    .br_sext   (br_sext),
    .cmp_valid (cmp_valid),
    .cmp_taken (cmp_taken),
    .j_req     (j_req),
    .j_index   (j_index),
    .jr_req    (jr_req),
    .jr_addr   (jr_addr),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .br_wait   (br_wait),
    .redirect  (redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic        br_req;
    logic [15:0] br_imm;
    logic        br_sext;
    logic        cmp_valid;
    logic        cmp_taken;
    logic        j_req;
    logic [25:0] j_index;
    logic        jr_req;
    logic [31:0] jr_addr;
    logic [31:0] exp_pc;
    logic        exp_redirect;
    logic        exp_br_wait;
  } vec_t;

  function automatic vec_t mk(string name, logic r, logic st, logic br,
                              logic [15:0] imm, logic sx, logic cv, logic ct,
                              logic j, logic [25:0] jidx, logic jr,
                              logic [31:0] jaddr, logic [31:0] epc,
                              logic erd, logic ebw);
    vec_t v;
    v.name = name; v.rst = r; v.stall = st; v.br_req = br; v.br_imm = imm;
    v.br_sext = sx; v.cmp_valid = cv; v.cmp_taken = ct; v.j_req = j;
    v.j_index = jidx; v.jr_req = jr; v.jr_addr = jaddr; v.exp_pc = epc;
    v.exp_redirect = erd; v.exp_br_wait = ebw;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; stall = v.stall; br_req = v.br_req; br_imm = v.br_imm;
    br_sext = v.br_sext; cmp_valid = v.cmp_valid; cmp_taken = v.cmp_taken;
    j_req = v.j_req; j_index = v.j_index; jr_req = v.jr_req;
    jr_addr = v.jr_addr;
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_vec(vec_t v);
    drive(v);
    tick();
    check({v.name, ".pc"},       pc,                v.exp_pc);
    check({v.name, ".pc_plus4"}, pc_plus4,          v.exp_pc + 32'd4);
    check({v.name, ".redirect"}, {31'd0, redirect}, {31'd0, v.exp_redirect});
    check({v.name, ".br_wait"},  {31'd0, br_wait},  {31'd0, v.exp_br_wait});
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc;
  logic        m_wait;
  logic [31:0] m_tgt;
  logic        m_rd;

  // Offset = imm * 4 as an 18-bit quantity; signed values are imm*4 - 2^18.
  function automatic logic [31:0] model_off(logic [15:0] imm, logic sx);
    logic [31:0] o;
    o = 32'(imm) * 32'd4;
    if (sx && imm >= 16'h8000) o = o - 32'h0004_0000;
    return o;
  endfunction

  task automatic model_step();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (rst) begin
      m_pc = 32'd0; m_wait = 1'b0; m_tgt = 32'd0; m_rd = 1'b0;
    end else if (stall) begin
      m_rd = 1'b0;
    end else if (m_wait) begin
      m_rd = 1'b0;
      if (cmp_valid) begin
        m_pc   = cmp_taken ? m_tgt : seq;
        m_rd   = cmp_taken;
        m_wait = 1'b0;
      end
    end else if (jr_req) begin
      m_pc = jr_addr; m_rd = 1'b1;
    end else if (j_req) begin
      m_pc = (seq & 32'hF000_0000) | (32'(j_index) * 32'd4);
      m_rd = 1'b1;
    end else if (br_req) begin
      if (cmp_valid) begin
        m_pc = cmp_taken ? seq + model_off(br_imm, br_sext) : seq;
        m_rd = cmp_taken;
      end else begin
        m_tgt  = seq + model_off(br_imm, br_sext);
        m_wait = 1'b1;
        m_rd   = 1'b0;
      end
    end else begin
      m_pc = seq; m_rd = 1'b0;
    end
  endtask

  vec_t tbl[$];

  initial begin
    drive(mk("init", 1, 0, 0, 16'h0, 0, 0, 0, 0, 26'h0, 0, 32'h0, 32'h0, 0, 0));

    // Directed table: reset, sequential, same-cycle and deferred branches.
    tbl.push_back(mk("rst0",     1,0,0,16'h0000,0,0,0,0,26'h0,0,32'h0,        32'h0000_0000,0,0));
    tbl.push_back(mk("rst1",     1,0,0,16'h0000,0,0,0,0,26'h0,0,32'h0,        32'h0000_0000,0,0));
    tbl.push_back(mk("seq4",     0,0,0,16'h0000,0,0,0,0,26'h0,0,32'h0,        32'h0000_0004,0,0));
    tbl.push_back(mk("seq8",     0,0,0,16'h0000,0,0,0,0,26'h0,0,32'h0,        32'h0000_0008,0,0));
    tbl.push_back(mk("seqC",     0,0,0,16'h0000,0,0,0,0,26'h0,0,32'h0,        32'h0000_000C,0,0));
    tbl.push_back(mk("jr100",    0,0,0,16'h0000,0,0,0,0,26'h0,1,32'h100,      32'h0000_0100,1,0));
    tbl.push_back(mk("br_neg_s", 0,0,1,16'hFFFE,1,1,1,0,26'h0,0,32'h0,        32'h0000_00FC,1,0));
    tbl.push_back(mk("seq100",   0,0,0,16'h0000,0,0,0,0,26'h0,0,32'h0,        32'h0000_0100,0,0));
    tbl.push_back(mk("br_neg_u", 0,0,1,16'hFFFE,0,1,1,0,26'h0,0,32'h0,        32'h0004_00FC,1,0));
    tbl.push_back(mk("jr200",    0,0,0,16'h0000,0,0,0,0,26'h0,1,32'h200,      32'h0000_0200,1,0));
    tbl.push_back(mk("br_defer", 0,0,1,16'h0010,1,0,0,0,26'h0,0,32'h0,        32'h0000_0200,0,1));
    tbl.push_back(mk("wait1",    0,0,0,16'h0000,0,0,0,0,26'h0,0,32'h0,        32'h0000_0200,0,1));
    tbl.push_back(mk("wait2_j",  0,0,1,16'h0040,0,0,0,1,26'h123,0,32'h0,      32'h0000_0200,0,1));
    tbl.push_back(mk("wait3_jr", 0,0,0,16'h0000,0,0,0,0,26'h0,1,32'hDEAD_BEE0,32'h0000_0200,0,1));
    tbl.push_back(mk("resolveT", 0,0,0,16'h0000,0,1,1,0,26'h0,0,32'h0,        32'h0000_0244,1,0));
    tbl.push_back(mk("jr200b",   0,0,0,16'h0000,0,0,0,0,26'h0,1,32'h200,      32'h0000_0200,1,0));
    tbl.push_back(mk("br_def2",  0,0,1,16'h0010,1,0,0,0,26'h0,0,32'h0,        32'h0000_0200,0,1));
    tbl.push_back(mk("resolveN", 0,0,0,16'h0000,0,1,0,0,26'h0,0,32'h0,        32'h0000_0204,0,0));
    tbl.push_back(mk("cv_norq",  0,0,0,16'h0000,0,1,1,0,26'h0,0,32'h0,        32'h0000_0208,0,0));
    tbl.push_back(mk("run_stl",  0,1,0,16'h0000,0,0,0,0,26'h0,1,32'h500,      32'h0000_0208,0,0));

    for (int i = 0; i < tbl.size(); i++) do_vec(tbl[i]);

    // Stall in BR_WAIT: a valid compare must not be consumed while stalled.
    do_vec(mk("sw_jr",   0,0,0,16'h0000,0,0,0,0,26'h0,1,32'h300,32'h0000_0300,1,0));
    do_vec(mk("sw_br",   0,0,1,16'h0001,1,0,0,0,26'h0,0,32'h0,  32'h0000_0300,0,1));
    do_vec(mk("sw_st1",  0,1,0,16'h0000,0,1,1,0,26'h0,0,32'h0,  32'h0000_0300,0,1));
    do_vec(mk("sw_st2",  0,1,0,16'h0000,0,1,1,0,26'h0,0,32'h0,  32'h0000_0300,0,1));
    do_vec(mk("sw_go",   0,0,0,16'h0000,0,1,1,0,26'h0,0,32'h0,  32'h0000_0308,1,0));

    // Priority, jump region and PC wrap.
    do_vec(mk("pr_jr0",  0,0,0,16'h0000,0,0,0,0,26'h0,1,32'h1000_0000,32'h1000_0000,1,0));
    do_vec(mk("pr_all",  0,0,1,16'h0004,1,1,1,1,26'h155,1,32'h8000_0003,32'h8000_0003,1,0));
    do_vec(mk("pr_j",    0,0,1,16'h0004,1,1,1,1,26'h3FF_FFFF,0,32'h0,32'h8FFF_FFFC,1,0));
    do_vec(mk("pr_jrw",  0,0,0,16'h0000,0,0,0,0,26'h0,1,32'hFFFF_FFFC,32'hFFFF_FFFC,1,0));
    do_vec(mk("wrap",    0,0,0,16'h0000,0,0,0,0,26'h0,0,32'h0,32'h0000_0000,0,0));

    // Reset mid-branch abandons the pending branch and returns to RUN.
    do_vec(mk("rb_jr",   0,0,0,16'h0000,0,0,0,0,26'h0,1,32'h400,32'h0000_0400,1,0));
    do_vec(mk("rb_br",   0,0,1,16'h0008,0,0,0,0,26'h0,0,32'h0,  32'h0000_0400,0,1));
    do_vec(mk("rb_rst",  1,0,0,16'h0000,0,1,1,0,26'h0,0,32'h0,  32'h0000_0000,0,0));
    do_vec(mk("rb_run",  0,0,0,16'h0000,0,0,0,0,26'h0,0,32'h0,  32'h0000_0004,0,0));

    // Randomized run against the behavioural model, starting from reset.
    drive(mk("rnd_rst", 1,0,0,16'h0,0,0,0,0,26'h0,0,32'h0,32'h0,0,0));
    model_step();
    tick();
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      jr_req    = ($urandom_range(0, 9) == 0);
      j_req     = ($urandom_range(0, 9) == 0);
      br_req    = ($urandom_range(0, 2) == 0);
      br_imm    = 16'($urandom);
      br_sext   = 1'($urandom);
      cmp_valid = 1'($urandom);
      cmp_taken = 1'($urandom);
      j_index   = 26'($urandom);
      jr_addr   = $urandom;
      model_step();
      tick();
      check("rnd.pc",       pc,                m_pc);
      check("rnd.pc_plus4", pc_plus4,          m_pc + 32'd4);
      check("rnd.redirect", {31'd0, redirect}, {31'd0, m_rd});
      check("rnd.br_wait",  {31'd0, br_wait},  {31'd0, m_wait});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
